mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the core's memory ports: the instruction-fetch port (64-bit fetch, active-low enable) and the store-queue data port.
- Arbitrates both onto a single 32-bit single-port SRAM with fixed read latency.
- Splits each 64-bit fetch into two consecutive 32-bit beats and returns read data with one-cycle valid pulses.
- Back-pressures the core with busy outputs and discards in-flight fetch data on a pipeline flush.

Parameters:
- LATENCY, 1: cycles from an SRAM op appearing on the port to its read data on IN_sRData (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_iAddr  in  29  fetch address, 64-bit aligned
- IN_iCe  in  1  fetch request, active-low
- OUT_iBusy  out  1  fetch request not accepted this cycle; core holds it
- OUT_instr  out  64  fetched instruction pair {hi word, lo word}
- OUT_instrValid  out  1  OUT_instr valid, one-cycle pulse
- IN_flush  in  1  discard all in-flight fetch work
- IN_dAddr  in  30  data word address
- IN_dWData  in  32  write data
- IN_dWe  in  1  data write, active-low
- IN_dCe  in  1  data access enable, active-low
- IN_dWm  in  4  byte write mask
- OUT_dBusy  out  1  data request not accepted this cycle
- OUT_dRData  out  32  read data
- OUT_dValid  out  1  read data valid, one-cycle pulse
- OUT_sAddr  out  30  SRAM word address
- OUT_sWData  out  32  SRAM write data
- OUT_sCe  out  1  SRAM enable, active-low
- OUT_sWe  out  1  SRAM write, active-low
- OUT_sWm  out  4  SRAM byte mask
- IN_sRData  in  32  SRAM read data

Behaviour:
- Request decoding:
  - Data request = !IN_dCe || !IN_dWe.
  - Write if !IN_dWe, otherwise read.
  - Writes produce no response.
- One SRAM op is accepted per cycle; accepted ops are registered onto the OUT_s* port in the next cycle. Idle cycle drives OUT_sCe=1, OUT_sWe=1.
- FSM states: IDLE, FETCH_HI.
  - IDLE:
    - Data request present → accept data; stay IDLE.
    - Else fetch request present and !IN_flush → accept; issue lo beat {IN_iAddr,1'b0}; latch IN_iAddr; go FETCH_HI.
  - FETCH_HI:
    - Issue hi beat {latched,1'b1}; go IDLE.
    - Data request is refused this cycle.
    - If IN_flush: no hi beat is issued; go IDLE; a data request may be accepted this cycle.
- Busy outputs (combinational):
  - OUT_dBusy = data request && not accepted.
  - OUT_iBusy = !IN_iCe && not accepted.
  - Core must hold a refused request unchanged.
- Sustained throughput: one fetch per 2 cycles, or one data op per cycle. Data starves fetch by design; the core's store queue is bounded.
- Response tracking:
  - Shift register of depth LATENCY+1 holding {valid, kind}, kind ∈ {I_LO, I_HI, D}.
  - An entry is pushed when its op is accepted, for reads only.
  - The entry reaching the end aligns with IN_sRData: op accepted at t → port at t+1 → data at t+1+LATENCY.
- Response handling:
  - I_LO: capture IN_sRData into lo register.
  - I_HI: OUT_instr={IN_sRData, lo}, OUT_instrValid=1.
  - D: OUT_dRData=IN_sRData, OUT_dValid=1.
  - Data output is combinational from IN_sRData; valids come from registered tracking state.
- IN_flush:
  - Clears valid on every in-flight I_LO/I_HI entry in the same cycle (including any arriving that cycle), so no OUT_instrValid results.
  - D entries are unaffected.
  - A fetch in the flush cycle is refused.
- An orphan I_HI whose I_LO was flushed cannot occur: both are cleared together.
- Reset:
  - FSM → IDLE; tracking valids cleared; lo register 0.
  - OUT_sCe=1, OUT_sWe=1, OUT_sAddr=0, OUT_sWData=0, OUT_sWm=0.
  - OUT_instrValid=0, OUT_dValid=0; OUT_instr/OUT_dRData don't-care but drive 0 when not valid.
  - Reset mid-fetch drops the fetch silently.
- Address arithmetic: beat address = {IN_iAddr, beat}, 30 bits, no overflow possible.

Test Plan:
- Fetch, LATENCY=1: IN_iCe=0, IN_iAddr=0x10 at t0 → OUT_sAddr=0x20 (sCe=0) t1, 0x21 t2; SRAM returns 0x11111111, 0x22222222 → OUT_instrValid=1 at t3 only, OUT_instr=0x2222222211111111.
- Conflict at t0: data read addr 0x100 plus fetch addr 0x8 → OUT_iBusy=1, OUT_dBusy=0 at t0; sAddr=0x100 t1; OUT_dValid t2; fetch accepted t1, lo beat sAddr=0x10 t2.
- Write: IN_dWe=0, addr 0x3FF, data 0xDEADBEEF, wm 4'b0011 → t1: sWe=0, sCe=0, sAddr=0x3FF, sWm=0011, sWData=0xDEADBEEF; no OUT_dValid ever.
- Data during FETCH_HI: fetch accepted t0, data read at t1 → OUT_dBusy=1 at t1; data accepted t2, OUT_dValid t4; OUT_instrValid t3.
- Flush: fetch accepted t0, IN_flush=1 at t1 → no hi beat at t2, no OUT_instrValid through t6; new fetch 0x4 at t2 → OUT_instrValid at t5.
- Reset mid-op, LATENCY=3: fetch accepted t0, rst=1 at t2 → no OUT_instrValid; sCe=1 at t3; fetch issued t4 completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch (two 32-bit beats) and data ports onto one 32-bit SRAM with fixed read latency
module mem_port_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] IN_iAddr,
  input  logic        IN_iCe,
  output logic        OUT_iBusy,
  output logic [63:0] OUT_instr,
  output logic        OUT_instrValid,
  input  logic        IN_flush,
  input  logic [29:0] IN_dAddr,
  input  logic [31:0] IN_dWData,
  input  logic        IN_dWe,
  input  logic        IN_dCe,
  input  logic [3:0]  IN_dWm,
  output logic        OUT_dBusy,
  output logic [31:0] OUT_dRData,
  output logic        OUT_dValid,
  output logic [29:0] OUT_sAddr,
  output logic [31:0] OUT_sWData,
  output logic        OUT_sCe,
  output logic        OUT_sWe,
  output logic [3:0]  OUT_sWm,
  input  logic [31:0] IN_sRData
);
  typedef enum logic {IDLE, FETCH_HI} state_e;
  localparam logic [1:0] K_ILO = 2'd0;
  localparam logic [1:0] K_IHI = 2'd1;
  localparam logic [1:0] K_D = 2'd2;
  state_e state_q, state_d;
  logic [29:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic s_ce_q, s_ce_d, s_we_q, s_we_d;
  logic [3:0] s_wm_q, s_wm_d;
  logic [28:0] hi_addr_q, hi_addr_d;
  logic [31:0] lo_q, lo_d;
  logic [LATENCY:0] vld_q, vld_d;
  logic [LATENCY:0][1:0] kind_q, kind_d;
  logic d_req, d_wr, i_req, d_acc, i_acc, hi_acc, rsp_lo, rsp_hi, rsp_d;
  always_comb begin
    d_req = !IN_dCe || !IN_dWe;
    d_wr = !IN_dWe;
    i_req = !IN_iCe;
    hi_acc = state_q == FETCH_HI && !IN_flush;
    d_acc = d_req && (state_q == IDLE || IN_flush);
    i_acc = state_q == IDLE && !d_req && i_req && !IN_flush;
    state_d = i_acc ? FETCH_HI : IDLE;
    hi_addr_d = i_acc ? IN_iAddr : hi_addr_q;
    s_ce_d = !(d_acc || i_acc || hi_acc);
    s_we_d = !(d_acc && d_wr);
    s_addr_d = d_acc ? IN_dAddr : i_acc ? {IN_iAddr, 1'b0} : hi_acc ? {hi_addr_q, 1'b1} : s_addr_q;
    s_wdata_d = d_acc ? IN_dWData : s_wdata_q;
    s_wm_d = d_acc ? IN_dWm : s_wm_q;
    vld_d[0] = (d_acc && !d_wr) || i_acc || hi_acc;
    kind_d[0] = d_acc ? K_D : i_acc ? K_ILO : K_IHI;
    for (int k = 1; k <= LATENCY; k++) begin
      vld_d[k] = vld_q[k-1] && !(IN_flush && kind_q[k-1] != K_D);
      kind_d[k] = kind_q[k-1];
    end
    // the entry at the tail lines up with IN_sRData; a flush also kills a fetch beat arriving now
    rsp_d = vld_q[LATENCY] && kind_q[LATENCY] == K_D;
    rsp_lo = vld_q[LATENCY] && kind_q[LATENCY] == K_ILO && !IN_flush;
    rsp_hi = vld_q[LATENCY] && kind_q[LATENCY] == K_IHI && !IN_flush;
    lo_d = rsp_lo ? IN_sRData : lo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      s_ce_q <= 1'b1;
      s_we_q <= 1'b1;
      s_wm_q <= '0;
      hi_addr_q <= '0;
      lo_q <= '0;
      vld_q <= '0;
      kind_q <= '0;
    end else begin
      state_q <= state_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_ce_q <= s_ce_d;
      s_we_q <= s_we_d;
      s_wm_q <= s_wm_d;
      hi_addr_q <= hi_addr_d;
      lo_q <= lo_d;
      vld_q <= vld_d;
      kind_q <= kind_d;
    end
  end
  assign OUT_iBusy = i_req && !i_acc;
  assign OUT_dBusy = d_req && !d_acc;
  assign OUT_sAddr = s_addr_q;
  assign OUT_sWData = s_wdata_q;
  assign OUT_sCe = s_ce_q;
  assign OUT_sWe = s_we_q;
  assign OUT_sWm = s_wm_q;
  assign OUT_instrValid = rsp_hi;
  assign OUT_instr = rsp_hi ? {IN_sRData, lo_q} : 64'd0;
  assign OUT_dValid = rsp_d;
  assign OUT_dRData = rsp_d ? IN_sRData : 32'd0;
endmodule
